// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Optional feature macro used by this slice: IF_EARLY_JUMP_EN.
package if_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [5:0]  OPC_J     = 6'b000010;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  // A bubble carries no instruction and zeroed addresses.
  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC selection for the fetch stage.
// Priority: redirect, early J (only when IF_EARLY_JUMP_EN is defined), stall, pc + 4.
// Reset is applied by the PC register in the top module, not here.
module if_next_pc
  import if_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ifid_valid,
  input  logic [31:0] ifid_pc4,
  input  logic [31:0] ifid_instr,
  output logic [31:0] next_pc,
  output logic        early_jump
);

`ifdef IF_EARLY_JUMP_EN
  localparam bit EARLY_JUMP_ON = 1'b1;
`else
  localparam bit EARLY_JUMP_ON = 1'b0;
`endif

  logic [31:0] jump_target;
  logic        jump_hit;

  // Redirect targets are word-aligned by dropping the low bits; only the top
  // nibble of pc4 feeds the J region, the rest is intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], ifid_pc4[27:0]};

  // J target and trigger: a live, unstalled J sitting in IF/ID.
  always_comb begin
    jump_target = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};
    jump_hit    = EARLY_JUMP_ON && ifid_valid && (ifid_instr[31:26] == OPC_J) && !stall;
  end

  // Priority mux; a redirect always beats an early jump and a stall.
  always_comb begin
    next_pc    = pc + PC_STEP;
    early_jump = 1'b0;
    if (redirect_valid) begin
      next_pc = {redirect_pc[31:2], 2'b00};
    end else if (jump_hit) begin
      next_pc    = jump_target;
      early_jump = 1'b1;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem address drive and IF/ID register.
// Optional early J resolution is enabled by defining IF_EARLY_JUMP_EN.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr
);

  // Handshake: ifid_valid high means IF/ID holds a live instruction that
  // decode may consume; there is no ready back-pressure, the hazard unit
  // instead holds the stage with stall and kills the slot with flush.

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] next_pc;
  logic        early_jump;

  if_next_pc u_next_pc (
    .pc             (pc_q),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_q.valid),
    .ifid_pc4       (ifid_q.pc4),
    .ifid_instr     (ifid_q.instr),
    .next_pc        (next_pc),
    .early_jump     (early_jump)
  );

  // PC follows the selected next-PC every cycle.
  always_comb begin
    pc_d = next_pc;
  end

  // IF/ID: bubble on flush/redirect/early jump, hold on stall, else capture.
  always_comb begin
    ifid_d = ifid_q;
    if (flush || redirect_valid || early_jump) begin
      ifid_d = IFID_BUBBLE;
    end else if (!stall) begin
      ifid_d.valid = 1'b1;
      ifid_d.pc    = pc_q;
      ifid_d.pc4   = pc_q + PC_STEP;
      ifid_d.instr = imem_instr;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ifid_q <= IFID_BUBBLE;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_valid = ifid_q.valid;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_instr = ifid_q.instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with a queue-based scoreboard.
// Expectations for the early-jump case follow IF_EARLY_JUMP_EN.
module tb_if_fetch_stage;

  localparam int W = 129; // {imem_addr, valid, pc, pc4, instr}

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] J_INSTR = 32'h0800_0011; // J to 0x44

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_pc4       (ifid_pc4),
    .ifid_instr     (ifid_instr)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Combinational instruction memory image
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:  mem = 32'h2002_0005;
      32'h4:  mem = 32'h2003_000c;
      32'h8:  mem = 32'h2007_0003;
      32'h3c: mem = J_INSTR;
      default: mem = 32'hA000_0000 | a;
    endcase
  endfunction

  always_comb imem_instr = mem(imem_addr);

  // Driver: apply one cycle of inputs and push the expected post-edge state
  task automatic step(input logic r, input logic s, input logic f,
                      input logic rv, input logic [31:0] rpc,
                      input logic [31:0] e_addr, input logic e_v,
                      input logic [31:0] e_pc, input logic [31:0] e_instr);
    logic [31:0] e_pc4;
    rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    e_pc4 = e_v ? (e_pc + 32'd4) : 32'h0;
    @(posedge clk);
    exp_q.push_back({e_addr, e_v, e_pc, e_pc4, e_instr});
    #1;
  endtask

  task automatic run(input logic [31:0] e_addr, input logic [31:0] e_pc, input logic [31:0] e_instr);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e_addr, 1'b1, e_pc, e_instr);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Scoreboard monitor: compare on the falling edge after each update
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("imem_addr",  imem_addr,            e[128:97]);
      check("ifid_valid", {31'h0, ifid_valid},  {31'h0, e[96]});
      check("ifid_pc",    ifid_pc,              e[95:64]);
      check("ifid_pc4",   ifid_pc4,             e[63:32]);
      check("ifid_instr", ifid_instr,           e[31:0]);
    end
  end

  initial begin
    int budget;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    // Sequential fetch 0, 4, 8
    run(32'h4,  32'h0, 32'h2002_0005);
    run(32'h8,  32'h4, 32'h2003_000c);
    run(32'hc,  32'h8, 32'h2007_0003);
    // Two stall cycles at pc 12
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hc, 1'b1, 32'h8, 32'h2007_0003);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hc, 1'b1, 32'h8, 32'h2007_0003);
    run(32'h10, 32'hc,  32'hA000_000c);
    run(32'h14, 32'h10, 32'hA000_0010);
    run(32'h18, 32'h14, 32'hA000_0014);
    run(32'h1c, 32'h18, 32'hA000_0018);
    // Redirect at pc 28 to 0x44
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h44, 1'b0, 32'h0, 32'h0);
    run(32'h48, 32'h44, 32'hA000_0044);
    // Misaligned redirect target is forced to a word boundary
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h46, 32'h44, 1'b0, 32'h0, 32'h0);
    run(32'h48, 32'h44, 32'hA000_0044);
    // stall + flush + redirect together, then stall alone holds the bubble
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h10, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h10, 1'b0, 32'h0, 32'h0);
    run(32'h14, 32'h10, 32'hA000_0010);
    // J at 0x3c, held by a stall first
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3c, 32'h3c, 1'b0, 32'h0, 32'h0);
    run(32'h40, 32'h3c, J_INSTR);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40, 1'b1, 32'h3c, J_INSTR);
`ifdef IF_EARLY_JUMP_EN
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h44, 1'b0, 32'h0, 32'h0);
`else
    run(32'h44, 32'h40, 32'hA000_0040);
`endif
    run(32'h48, 32'h44, 32'hA000_0044);
    // Flush alone: pc advances, IF/ID bubbles
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h4c, 1'b0, 32'h0, 32'h0);
    run(32'h50, 32'h4c, 32'hA000_004c);
    // Wrap at the top of the address space
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    run(32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    run(32'h4, 32'h0, 32'h2002_0005);
    // Reset mid-stream, then fetch restarts at RESET_PC
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    run(32'h4, 32'h0, 32'h2002_0005);
    run(32'h8, 32'h4, 32'h2003_000c);

    // Drain the scoreboard with a bounded wait
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the byte address into the combinational instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register.
- Honours hazard-unit stall/flush and the EX-stage branch redirect; optionally resolves J-type jumps one stage early.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold PC and IF/ID contents (load-use hazard)
- flush  input  1  replace IF/ID contents with a bubble on next edge
- redirect_valid  input  1  taken branch/jump resolved downstream
- redirect_pc  input  32  target byte address for redirect
- imem_addr  output  32  byte address to instruction memory (= PC, combinational)
- imem_instr  input  32  instruction word returned same cycle
- ifid_valid  output  1  IF/ID holds a live instruction
- ifid_pc  output  32  address of the IF/ID instruction
- ifid_pc4  output  32  ifid_pc + 4
- ifid_instr  output  32  instruction word; 32'h0 (NOP) when bubble

Behaviour:
- Single clock domain; reset is synchronous, active-high, sampled on rising clk.
- Reset values:
  - pc = RESET_PC
  - ifid_valid = 0, ifid_pc = 0, ifid_pc4 = 0, ifid_instr = 32'h0
- Latency: imem_addr reflects pc in the same cycle. The fetched word appears on ifid_instr after the next rising edge (1 cycle).
- Next-PC priority, highest first:
  1. rst → RESET_PC
  2. redirect_valid → {redirect_pc[31:2], 2'b00}; low bits are forced to zero silently
  3. early jump (only with the optional feature)
  4. stall → hold pc
  5. otherwise pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0
- IF/ID update priority, highest first:
  1. rst → reset values
  2. flush or redirect_valid → bubble: valid = 0, instr = 0, pc and pc4 = 0
  3. stall → hold all fields
  4. otherwise load valid = 1, pc, pc + 4, imem_instr
- Simultaneous events:
  - stall with redirect_valid: redirect wins for both PC and IF/ID; the branch is never lost.
  - stall with flush: the bubble is inserted.
- Reset mid-operation discards all in-flight state; fetch restarts at RESET_PC on the first cycle after rst deasserts.
- Unmapped addresses return whatever imem_instr presents (memory defines don't-care). The stage does not check this.
- No internal state machine beyond the PC and IF/ID registers.

Optional Feature:
- Macro: IF_EARLY_JUMP_EN.
- Defined:
  - Trigger: ifid_valid = 1, ifid_instr[31:26] = 6'b000010 (J), and stall = 0.
  - Action: next pc = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00}.
  - The word fetched that cycle is squashed (IF/ID becomes a bubble). Jump penalty is 1 cycle.
  - redirect_valid still overrides the early jump.
  - A stalled J is held and acts when the stall releases.
- Undefined: J is treated like any other instruction; only redirect_valid changes control flow.

Decomposition:
- Package if_pkg holds:
  - NOP_INSTR = 32'h0
  - PC_STEP = 32'd4
  - OPC_J = 6'b000010
  - typedef ifid_t {valid, pc, pc4, instr}
- One sub-module, if_next_pc: combinational next-PC priority mux, including the early-jump target computation.
- PC register and IF/ID register live in the top module.

Test Plan:
- Reset then run with memory image 0x20020005 @0, 0x2003000c @4, 0x20070003 @8:
  - imem_addr goes 0, 4, 8.
  - One cycle after each address, ifid_instr is 0x20020005, 0x2003000c, 0x20070003 with ifid_valid = 1.
  - ifid_pc4 = ifid_pc + 4.
- Assert stall 2 cycles while pc = 12:
  - imem_addr stays 12.
  - ifid_instr holds 0x20070003.
  - Fetch resumes at 16, then 20.
- At pc = 28, pulse redirect_valid with redirect_pc = 0x44:
  - Next imem_addr = 0x44.
  - IF/ID = bubble (valid 0, instr 0).
  - redirect_pc = 0x46 also gives 0x44.
- Assert stall, flush and redirect_valid (0x10) together:
  - pc → 0x10 and IF/ID bubble.
  - Then stall alone at pc 0x10 holds the bubble.
- With IF_EARLY_JUMP_EN, J 0x08000011 at 60:
  - On the cycle after it is in IF/ID, pc = 0x44.
  - The word from 64 is squashed.
  - Without the macro, 64 is fetched normally.
- Force pc to 0xFFFF_FFFC via redirect:
  - Next imem_addr = 0.
  - Assert rst mid-stream: pc = RESET_PC and ifid_valid = 0 on the next edge.
